// File: rtl/ascii_updown_counter.sv
// Up/down counter that holds its value as ASCII decimal digits, with load, ERR capture and limit pulses.
// WRAP=0 saturates at all "0" / all "9"; WRAP=1 wraps modulo 10^DIGITS.
module ascii_updown_counter #(
  parameter int unsigned DIGITS = 2,
  parameter int unsigned WRAP   = 0
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic [8*DIGITS-1:0]   ascii_in,
  input  logic                  load,
  input  logic                  up,
  input  logic                  down,
  output logic [8*DIGITS-1:0]   cnt,
  output logic                  done,
  output logic                  err,
  output logic                  ovf,
  output logic                  unf
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2,
    ERR  = 2'd3
  } state_e;

  localparam logic [8*DIGITS-1:0] ALL_ZERO = {DIGITS{8'h30}};
  localparam logic [8*DIGITS-1:0] ALL_NINE = {DIGITS{8'h39}};
  localparam logic [8*DIGITS-1:0] ALL_E    = {DIGITS{8'h45}};

  state_e                state_q, state_d;
  logic [8*DIGITS-1:0]   cnt_q, cnt_d;
  logic                  done_q, done_d;
  logic                  err_q, err_d;
  logic                  ovf_q, ovf_d;
  logic                  unf_q, unf_d;

  function automatic logic [8*DIGITS-1:0] bcd_inc(input logic [8*DIGITS-1:0] v);
    logic       carry;
    logic [7:0] dig;
    bcd_inc = v;
    carry   = 1'b1;
    for (int unsigned i = 0; i < DIGITS; i++) begin
      dig = v[8*i +: 8];
      if (carry) begin
        if (dig == 8'h39) begin
          dig = 8'h30;
        end else begin
          dig   = dig + 8'd1;
          carry = 1'b0;
        end
      end
      bcd_inc[8*i +: 8] = dig;
    end
  endfunction

  function automatic logic [8*DIGITS-1:0] bcd_dec(input logic [8*DIGITS-1:0] v);
    logic       borrow;
    logic [7:0] dig;
    bcd_dec = v;
    borrow  = 1'b1;
    for (int unsigned i = 0; i < DIGITS; i++) begin
      dig = v[8*i +: 8];
      if (borrow) begin
        if (dig == 8'h30) begin
          dig = 8'h39;
        end else begin
          dig    = dig - 8'd1;
          borrow = 1'b0;
        end
      end
      bcd_dec[8*i +: 8] = dig;
    end
  endfunction

  function automatic logic all_decimal(input logic [8*DIGITS-1:0] v);
    all_decimal = 1'b1;
    for (int unsigned i = 0; i < DIGITS; i++) begin
      if (v[8*i +: 8] < 8'h30 || v[8*i +: 8] > 8'h39) all_decimal = 1'b0;
    end
  endfunction

  logic                step_up, step_dn;
  logic [8*DIGITS-1:0] inc_val, dec_val;

  always_comb begin
    step_up = up & ~down;
    step_dn = down & ~up;
    inc_val = bcd_inc(cnt_q);
    dec_val = bcd_dec(cnt_q);
    state_d = state_q;
    cnt_d   = cnt_q;
    ovf_d   = 1'b0;
    unf_d   = 1'b0;

    if (load) begin
      if (all_decimal(ascii_in)) begin
        cnt_d   = ascii_in;
        state_d = (ascii_in == ALL_ZERO) ? DONE : RUN;
      end else begin
        cnt_d   = ALL_E;
        state_d = ERR;
      end
    end else if (state_q == RUN || state_q == DONE) begin
      // Limits are detected on the value itself; all "0" only ever coexists with DONE.
      if (step_up) begin
        if (cnt_q == ALL_NINE) begin
          ovf_d = 1'b1;
          if (WRAP != 0) begin
            cnt_d   = ALL_ZERO;
            state_d = DONE;
          end
        end else begin
          cnt_d   = inc_val;
          state_d = RUN;
        end
      end else if (step_dn) begin
        if (cnt_q == ALL_ZERO) begin
          unf_d = 1'b1;
          if (WRAP != 0) begin
            cnt_d   = ALL_NINE;
            state_d = RUN;
          end
        end else begin
          cnt_d   = dec_val;
          state_d = (dec_val == ALL_ZERO) ? DONE : RUN;
        end
      end
    end

    done_d = (state_d == DONE);
    err_d  = (state_d == ERR);
  end

  always_ff @(posedge clock) begin
    if (!reset) begin
      state_q <= IDLE;
      cnt_q   <= ALL_ZERO;
      done_q  <= 1'b0;
      err_q   <= 1'b0;
      ovf_q   <= 1'b0;
      unf_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      done_q  <= done_d;
      err_q   <= err_d;
      ovf_q   <= ovf_d;
      unf_q   <= unf_d;
    end
  end

  assign cnt  = cnt_q;
  assign done = done_q;
  assign err  = err_q;
  assign ovf  = ovf_q;
  assign unf  = unf_q;

endmodule

// File: tb/tb_ascii_updown_counter.sv
// Bench for ascii_updown_counter: four parameterisations share one stimulus stream and are
// checked against a numeric reference model plus directed constants.
module tb_ascii_updown_counter;

  logic        clock;
  logic        reset, load, up, down;
  logic [31:0] a32;

  logic [15:0] c0, c1;
  logic [23:0] c2;
  logic [31:0] c3;
  logic [3:0]  done_o, err_o, ovf_o, unf_o;
  logic [31:0] cnt_o [4];

  assign cnt_o[0] = {16'h0, c0};
  assign cnt_o[1] = {16'h0, c1};
  assign cnt_o[2] = {8'h0, c2};
  assign cnt_o[3] = c3;

  ascii_updown_counter #(.DIGITS(2), .WRAP(0)) u_d2w0 (
    .clock(clock), .reset(reset), .ascii_in(a32[15:0]), .load(load), .up(up), .down(down),
    .cnt(c0), .done(done_o[0]), .err(err_o[0]), .ovf(ovf_o[0]), .unf(unf_o[0]));
  ascii_updown_counter #(.DIGITS(2), .WRAP(1)) u_d2w1 (
    .clock(clock), .reset(reset), .ascii_in(a32[15:0]), .load(load), .up(up), .down(down),
    .cnt(c1), .done(done_o[1]), .err(err_o[1]), .ovf(ovf_o[1]), .unf(unf_o[1]));
  ascii_updown_counter #(.DIGITS(3), .WRAP(0)) u_d3w0 (
    .clock(clock), .reset(reset), .ascii_in(a32[23:0]), .load(load), .up(up), .down(down),
    .cnt(c2), .done(done_o[2]), .err(err_o[2]), .ovf(ovf_o[2]), .unf(unf_o[2]));
  ascii_updown_counter #(.DIGITS(4), .WRAP(0)) u_d4w0 (
    .clock(clock), .reset(reset), .ascii_in(a32), .load(load), .up(up), .down(down),
    .cnt(c3), .done(done_o[3]), .err(err_o[3]), .ovf(ovf_o[3]), .unf(unf_o[3]));

  initial clock = 1'b0;
  always #5 clock = ~clock;

  // Reference model: count held as an integer, mode as 0 idle, 1 run, 2 done, 3 err.
  int dig_n  [4] = '{2, 2, 3, 4};
  int wrap_n [4] = '{0, 1, 0, 0};
  int mval   [4];
  int mst    [4];
  bit movf   [4];
  bit munf   [4];

  int checks = 0;
  int errors = 0;

  function automatic int maxv(int k);
    int m = 1;
    for (int i = 0; i < dig_n[k]; i++) m = m * 10;
    return m - 1;
  endfunction

  function automatic logic [31:0] exp_cnt(int k);
    logic [31:0] r = '0;
    int v = mval[k];
    for (int i = 0; i < dig_n[k]; i++) begin
      if (mst[k] == 3) r[8*i +: 8] = 8'h45;
      else             r[8*i +: 8] = 8'(48 + v % 10);
      v = v / 10;
    end
    return r;
  endfunction

  function automatic logic [3:0] exp_flags(int k);
    return {mst[k] == 2, mst[k] == 3, movf[k], munf[k]};
  endfunction

  task automatic model_step();
    for (int k = 0; k < 4; k++) begin
      int  v;
      bit  ok;
      logic [7:0] b;
      movf[k] = 1'b0;
      munf[k] = 1'b0;
      if (!reset) begin
        mval[k] = 0;
        mst[k]  = 0;
      end else if (load) begin
        ok = 1'b1;
        v  = 0;
        for (int i = dig_n[k] - 1; i >= 0; i--) begin
          b = a32[8*i +: 8];
          if (b < 8'h30 || b > 8'h39) ok = 1'b0;
          v = v * 10 + (int'(b) - 48);
        end
        if (ok) begin
          mval[k] = v;
          mst[k]  = (v == 0) ? 2 : 1;
        end else begin
          mst[k] = 3;
        end
      end else if ((mst[k] == 1 || mst[k] == 2) && up && !down) begin
        if (mval[k] == maxv(k)) begin
          movf[k] = 1'b1;
          if (wrap_n[k] != 0) begin mval[k] = 0; mst[k] = 2; end
        end else begin
          mval[k] = mval[k] + 1;
          mst[k]  = 1;
        end
      end else if ((mst[k] == 1 || mst[k] == 2) && down && !up) begin
        if (mval[k] == 0) begin
          munf[k] = 1'b1;
          if (wrap_n[k] != 0) begin mval[k] = maxv(k); mst[k] = 1; end
        end else begin
          mval[k] = mval[k] - 1;
          mst[k]  = (mval[k] == 0) ? 2 : 1;
        end
      end
    end
  endtask

  task automatic tick(input logic r, input logic l, input logic u, input logic d, input logic [31:0] a);
    reset = r; load = l; up = u; down = d; a32 = a;
    @(posedge clock);
    model_step();
    #1;
  endtask

  task automatic test_reset();
    tick(1'b0, 1'b0, 1'b0, 1'b0, "0000");
    tick(1'b0, 1'b1, 1'b1, 1'b0, "1234");
    for (int k = 0; k < 4; k++) begin
      checks++;
      if (cnt_o[k] !== exp_cnt(k) || {done_o[k], err_o[k], ovf_o[k], unf_o[k]} !== exp_flags(k)) begin
        errors++;
        $display("FAIL reset dut%0d cnt=%h flags=%b required cnt=%h flags=%b", k, cnt_o[k],
                 {done_o[k], err_o[k], ovf_o[k], unf_o[k]}, exp_cnt(k), exp_flags(k));
      end
    end
    checks++;
    if (c3 !== "0000" || {done_o, err_o, ovf_o, unf_o} !== 16'h0) begin
      errors++;
      $display("FAIL reset_const cnt=%h flags=%h required 30303030/0000", c3, {done_o, err_o, ovf_o, unf_o});
    end
    for (int n = 0; n < 3; n++) begin
      tick(1'b1, 1'b0, n[0], ~n[0], "0000");
      checks++;
      if (c0 !== "00" || done_o[0] !== 1'b0 || unf_o[0] !== 1'b0 || ovf_o[0] !== 1'b0) begin
        errors++;
        $display("FAIL idle_ignore cnt=%h done=%b ovf=%b unf=%b required 3030/0/0/0", c0, done_o[0], ovf_o[0], unf_o[0]);
      end
    end
  endtask

  task automatic test_count_down();
    tick(1'b1, 1'b1, 1'b0, 1'b0, "0012");
    for (int n = 1; n <= 14; n++) begin
      tick(1'b1, 1'b0, 1'b0, n <= 13, "0000");
      for (int k = 0; k < 4; k++) begin
        checks++;
        if (cnt_o[k] !== exp_cnt(k) || {done_o[k], err_o[k], ovf_o[k], unf_o[k]} !== exp_flags(k)) begin
          errors++;
          $display("FAIL count_down step%0d dut%0d cnt=%h flags=%b required cnt=%h flags=%b", n, k, cnt_o[k],
                   {done_o[k], err_o[k], ovf_o[k], unf_o[k]}, exp_cnt(k), exp_flags(k));
        end
      end
      if (n == 12) begin
        checks++;
        if (c0 !== "00" || done_o[0] !== 1'b1 || unf_o[0] !== 1'b0) begin
          errors++;
          $display("FAIL count_down_zero cnt=%h done=%b unf=%b required 3030/1/0", c0, done_o[0], unf_o[0]);
        end
      end
      if (n == 13) begin
        checks++;
        if (c0 !== "00" || unf_o[0] !== 1'b1 || done_o[0] !== 1'b1) begin
          errors++;
          $display("FAIL count_down_unf cnt=%h unf=%b done=%b required 3030/1/1", c0, unf_o[0], done_o[0]);
        end
      end
    end
  endtask

  task automatic test_wrap();
    tick(1'b1, 1'b1, 1'b0, 1'b0, "0000");
    tick(1'b1, 1'b0, 1'b0, 1'b1, "0000");
    checks++;
    if (c1 !== "99" || unf_o[1] !== 1'b1 || done_o[1] !== 1'b0) begin
      errors++;
      $display("FAIL wrap_down cnt=%h unf=%b done=%b required 3939/1/0", c1, unf_o[1], done_o[1]);
    end
    tick(1'b1, 1'b0, 1'b1, 1'b0, "0000");
    checks++;
    if (c1 !== "00" || ovf_o[1] !== 1'b1 || done_o[1] !== 1'b1 || unf_o[1] !== 1'b0) begin
      errors++;
      $display("FAIL wrap_up cnt=%h ovf=%b done=%b unf=%b required 3030/1/1/0", c1, ovf_o[1], done_o[1], unf_o[1]);
    end
    for (int k = 0; k < 4; k++) begin
      checks++;
      if (cnt_o[k] !== exp_cnt(k) || {done_o[k], err_o[k], ovf_o[k], unf_o[k]} !== exp_flags(k)) begin
        errors++;
        $display("FAIL wrap dut%0d cnt=%h flags=%b required cnt=%h flags=%b", k, cnt_o[k],
                 {done_o[k], err_o[k], ovf_o[k], unf_o[k]}, exp_cnt(k), exp_flags(k));
      end
    end
  endtask

  task automatic test_error();
    tick(1'b1, 1'b1, 1'b0, 1'b0, "01A0");
    checks++;
    if (c2 !== "EEE" || err_o[2] !== 1'b1) begin
      errors++;
      $display("FAIL error_load cnt=%h err=%b required 454545/1", c2, err_o[2]);
    end
    tick(1'b1, 1'b0, 1'b1, 1'b0, "0000");
    tick(1'b1, 1'b0, 1'b0, 1'b1, "0000");
    for (int k = 0; k < 4; k++) begin
      checks++;
      if (cnt_o[k] !== exp_cnt(k) || {done_o[k], err_o[k], ovf_o[k], unf_o[k]} !== exp_flags(k)) begin
        errors++;
        $display("FAIL error_hold dut%0d cnt=%h flags=%b required cnt=%h flags=%b", k, cnt_o[k],
                 {done_o[k], err_o[k], ovf_o[k], unf_o[k]}, exp_cnt(k), exp_flags(k));
      end
    end
    tick(1'b1, 1'b1, 1'b0, 1'b0, "0100");
    checks++;
    if (c2 !== "100" || err_o[2] !== 1'b0 || done_o[0] !== 1'b1) begin
      errors++;
      $display("FAIL error_exit cnt=%h err=%b d2done=%b required 313030/0/1", c2, err_o[2], done_o[0]);
    end
  endtask

  task automatic test_both_steps();
    tick(1'b1, 1'b1, 1'b1, 1'b1, "0040");
    tick(1'b1, 1'b0, 1'b1, 1'b1, "0000");
    checks++;
    if (c0 !== "40" || ovf_o !== 4'b0 || unf_o !== 4'b0) begin
      errors++;
      $display("FAIL both_steps cnt=%h ovf=%b unf=%b required 3430/0000/0000", c0, ovf_o, unf_o);
    end
    tick(1'b1, 1'b1, 1'b1, 1'b0, "9999");
    checks++;
    if (c3 !== "9999" || ovf_o !== 4'b0) begin
      errors++;
      $display("FAIL load_override cnt=%h ovf=%b required 39393939/0000", c3, ovf_o);
    end
  endtask

  task automatic test_reset_mid();
    tick(1'b1, 1'b1, 1'b0, 1'b0, "0057");
    tick(1'b1, 1'b0, 1'b0, 1'b1, "0000");
    tick(1'b1, 1'b0, 1'b0, 1'b1, "0000");
    tick(1'b0, 1'b0, 1'b0, 1'b1, "0000");
    checks++;
    if (c0 !== "00" || {done_o, err_o, ovf_o, unf_o} !== 16'h0) begin
      errors++;
      $display("FAIL reset_mid cnt=%h flags=%h required 3030/0000", c0, {done_o, err_o, ovf_o, unf_o});
    end
    for (int n = 0; n < 2; n++) begin
      tick(1'b1, 1'b0, 1'b0, 1'b1, "0000");
      for (int k = 0; k < 4; k++) begin
        checks++;
        if (cnt_o[k] !== exp_cnt(k) || {done_o[k], err_o[k], ovf_o[k], unf_o[k]} !== exp_flags(k)) begin
          errors++;
          $display("FAIL reset_mid_idle dut%0d cnt=%h flags=%b required cnt=%h flags=%b", k, cnt_o[k],
                   {done_o[k], err_o[k], ovf_o[k], unf_o[k]}, exp_cnt(k), exp_flags(k));
        end
      end
    end
  endtask

  task automatic test_boundary();
    tick(1'b1, 1'b1, 1'b0, 1'b0, "0999");
    tick(1'b1, 1'b0, 1'b1, 1'b0, "0000");
    checks++;
    if (c3 !== "1000" || ovf_o[3] !== 1'b0 || c2 !== "999" || ovf_o[2] !== 1'b1) begin
      errors++;
      $display("FAIL carry_chain d4=%h ovf4=%b d3=%h ovf3=%b required 31303030/0 393939/1", c3, ovf_o[3], c2, ovf_o[2]);
    end
    tick(1'b1, 1'b1, 1'b0, 1'b0, "9999");
    for (int n = 0; n < 3; n++) begin
      tick(1'b1, 1'b0, n < 2, 1'b0, "0000");
      checks++;
      if (c3 !== "9999" || ovf_o[3] !== (n < 2)) begin
        errors++;
        $display("FAIL sat_ovf cycle%0d cnt=%h ovf=%b required 39393939/%0d", n, c3, ovf_o[3], n < 2);
      end
      for (int k = 0; k < 4; k++) begin
        checks++;
        if (cnt_o[k] !== exp_cnt(k) || {done_o[k], err_o[k], ovf_o[k], unf_o[k]} !== exp_flags(k)) begin
          errors++;
          $display("FAIL boundary dut%0d cnt=%h flags=%b required cnt=%h flags=%b", k, cnt_o[k],
                   {done_o[k], err_o[k], ovf_o[k], unf_o[k]}, exp_cnt(k), exp_flags(k));
        end
      end
    end
  endtask

  task automatic test_random();
    logic [31:0] a;
    int r;
    for (int n = 0; n < 600; n++) begin
      for (int i = 0; i < 4; i++) begin
        r = $urandom_range(0, 9);
        if (r < 3)                                  a[8*i +: 8] = "0";
        else if (r < 6)                             a[8*i +: 8] = "9";
        else if (r == 9 && $urandom_range(0, 4) == 0) a[8*i +: 8] = 8'($urandom_range(0, 255));
        else                                        a[8*i +: 8] = 8'(48 + $urandom_range(0, 9));
      end
      tick($urandom_range(0, 49) != 0, $urandom_range(0, 9) == 0,
           $urandom_range(0, 2) == 0, $urandom_range(0, 2) == 0, a);
      for (int k = 0; k < 4; k++) begin
        checks++;
        if (cnt_o[k] !== exp_cnt(k) || {done_o[k], err_o[k], ovf_o[k], unf_o[k]} !== exp_flags(k)) begin
          errors++;
          $display("FAIL random cyc%0d dut%0d cnt=%h flags=%b required cnt=%h flags=%b", n, k, cnt_o[k],
                   {done_o[k], err_o[k], ovf_o[k], unf_o[k]}, exp_cnt(k), exp_flags(k));
        end
      end
    end
  endtask

  initial begin
    test_reset();
    test_count_down();
    test_wrap();
    test_error();
    test_both_steps();
    test_reset_mid();
    test_boundary();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/ascii_updown_counter.md
ASCII_UPDOWN_COUNTER -- requirements
Module: ascii_updown_counter

Interface
REQ-001 SHALL have parameter DIGITS, default 2: number of ASCII decimal digits held, legal range 1..8.
REQ-002 SHALL have parameter WRAP, default 0: 0 saturates at the count limits, 1 wraps modulo 10^DIGITS.
REQ-003 SHALL have port clock, input, 1: sole clock; all state updates on its rising edge.
REQ-004 SHALL have port reset, input, 1: synchronous, active-low reset.
REQ-005 SHALL have port ascii_in, input, 8*DIGITS: load value, one ASCII character per byte, most significant digit in the top byte.
REQ-006 SHALL have port load, input, 1: capture ascii_in on this edge.
REQ-007 SHALL have port up, input, 1: increment request.
REQ-008 SHALL have port down, input, 1: decrement request.
REQ-009 SHALL have port cnt, output, 8*DIGITS, registered: current count as ASCII digits, or the error pattern.
REQ-010 SHALL have port done, output, 1, registered: level, high while in state DONE.
REQ-011 SHALL have port err, output, 1, registered: level, high while in state ERR.
REQ-012 SHALL have port ovf, output, 1, registered: one-cycle pulse on an accepted up at the all-"9" value.
REQ-013 SHALL have port unf, output, 1, registered: one-cycle pulse on an accepted down at the all-"0" value.

Function
REQ-014 SHALL implement FSM states IDLE, RUN, DONE and ERR.
REQ-015 SHALL apply priority reset > load > up/down on every cycle.
REQ-016 SHALL treat up and down asserted together as no step, with no pulse.
REQ-017 SHALL ignore up/down in IDLE and ERR.
REQ-018 On load with every byte in "0".."9", SHALL set cnt = ascii_in and go to DONE if the value is all "0", else RUN.
REQ-019 On load with any byte outside "0".."9", SHALL set cnt to "E" in every byte and go to ERR.
REQ-020 Load SHALL be the only exit from ERR, and SHALL be accepted from any state.
REQ-021 On decrement, SHALL apply per-digit ASCII BCD arithmetic: digit "0" becomes "9" and borrows from the next digit; otherwise the digit decrements by 1.
REQ-022 On increment, SHALL apply per-digit ASCII BCD arithmetic: digit "9" becomes "0" and carries to the next digit; otherwise the digit increments by 1.
REQ-023 On down in RUN producing all "0", SHALL go to DONE; done SHALL be high in the same cycle cnt shows all "0".
REQ-024 On down in DONE with WRAP=0, SHALL hold cnt, pulse unf and stay in DONE.
REQ-025 On down in DONE with WRAP=1, SHALL set cnt to all "9", pulse unf and go to RUN.
REQ-026 On up at all "9" with WRAP=0, SHALL hold cnt and pulse ovf.
REQ-027 On up at all "9" with WRAP=1, SHALL set cnt to all "0", pulse ovf and go to DONE.
REQ-028 On up in DONE (not at all "9"), SHALL increment and go to RUN.
REQ-029 SHALL drive ovf/unf high for exactly the cycle following the accepted step, then low; with a step held every cycle, SHALL pulse on every cycle the step is accepted at the limit.
REQ-030 SHALL have a latency of one clock from input sample to updated cnt, done, err, ovf and unf; no combinational input-to-output path.
REQ-031 Load SHALL override a simultaneous up/down, and SHALL not pulse ovf/unf.

Reset
REQ-032 While reset = 0 at an edge, SHALL set cnt to all "0", state IDLE, done = 0, err = 0, ovf = 0, unf = 0.
REQ-033 Reset asserted mid-count or in ERR SHALL take effect on the next edge regardless of load/up/down.
REQ-034 After reset release, SHALL keep IDLE until the first load.

Verification
REQ-035 (DIGITS=2, WRAP=0) load "12", then 12 x down -> cnt steps "11".."10","09".."01","00"; done rises with "00"; a 13th down -> cnt "00", unf one cycle.
REQ-036 (DIGITS=2, WRAP=1) load "00", down -> cnt "99", unf pulse, done low; then up -> cnt "00", ovf pulse, done high.
REQ-037 (DIGITS=3) load "1A0" -> cnt "EEE", err=1; up/down ignored; load "100" -> err=0, cnt "100".
REQ-038 (DIGITS=2) load "40" with up=down=1 -> cnt "40"; next cycle up=down=1 -> cnt unchanged, no pulses.
REQ-039 (DIGITS=2) reset=0 during a down burst at "57" -> next cnt "00", IDLE, all flags low; down ignored until load.
REQ-040 (DIGITS=4, WRAP=0) load "0999", up -> "1000"; load "9999", up -> "9999", ovf pulse.
